// File: rtl/uc_multiciclo_pkg.sv
// Shared encodings for the multicycle control unit: state codes, opcodes
// and the mux/ALU select values driven by the FSM.
package uc_multiciclo_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_WDATA = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/uc_multiciclo_aludeco.sv
// ALU decoder: maps the FSM's aluOp plus funct3/funct7 to an ALU operation.
module aluDeco
    import uc_multiciclo_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] f3,
    input  logic       op5,
    input  logic       f7,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (f3)
                    // Only R-type (op5 set) with funct7 bit 5 means sub; addi stays add.
                    3'b000:  alu_control = (op5 & f7) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle RV32I control unit: Moore FSM sequencing the shared ALU,
// unified memory and register file over 3-5 cycles per instruction.
module uc_multiciclo
    import uc_multiciclo_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] f3,
    input  logic       f7,
    input  logic       zero,
    output logic       pcWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       irWrite,
    output logic [1:0] resSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] inmSrc,
    output logic [2:0] ALUControl,
    output logic       regWrite,
    output logic [3:0] estado
);

    state_t     state, next_state;
    logic [1:0] alu_op;
    logic       pc_update, branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = FETCH;
        adrSrc     = 1'b0;
        memWrite   = 1'b0;
        irWrite    = 1'b0;
        regWrite   = 1'b0;
        resSrc     = RES_ALUOUT;
        aluSrcA    = SRCA_PC;
        aluSrcB    = SRCB_WDATA;
        alu_op     = ALUOP_ADD;
        pc_update  = 1'b0;
        branch     = 1'b0;
        case (state)
            FETCH: begin
                irWrite    = 1'b1;
                aluSrcB    = SRCB_FOUR;
                resSrc     = RES_ALU;
                pc_update  = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                // Branch/jump target is formed here from oldPC + imm into aluOut.
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECR;
                    OP_ITYPE:     next_state = EXECI;
                    OP_JAL:       next_state = JAL;
                    OP_BEQ:       next_state = BEQ;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR: begin
                aluSrcA    = SRCA_A;
                aluSrcB    = SRCB_IMM;
                next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adrSrc     = 1'b1;
                next_state = MEMWB;
            end
            MEMWB: begin
                resSrc     = RES_DATA;
                regWrite   = 1'b1;
                next_state = FETCH;
            end
            MEMWRITE: begin
                adrSrc     = 1'b1;
                memWrite   = 1'b1;
                next_state = FETCH;
            end
            EXECR: begin
                aluSrcA    = SRCA_A;
                aluSrcB    = SRCB_WDATA;
                alu_op     = ALUOP_FUNCT;
                next_state = ALUWB;
            end
            ALUWB: begin
                regWrite   = 1'b1;
                next_state = FETCH;
            end
            EXECI: begin
                aluSrcA    = SRCA_A;
                aluSrcB    = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                next_state = ALUWB;
            end
            JAL: begin
                aluSrcA    = SRCA_OLDPC;
                aluSrcB    = SRCB_FOUR;
                pc_update  = 1'b1;
                next_state = ALUWB;
            end
            BEQ: begin
                aluSrcA    = SRCA_A;
                aluSrcB    = SRCB_WDATA;
                alu_op     = ALUOP_SUB;
                branch     = 1'b1;
                next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   inmSrc = IMM_S;
            OP_BEQ:  inmSrc = IMM_B;
            OP_JAL:  inmSrc = IMM_J;
            default: inmSrc = IMM_I;
        endcase
    end

    aluDeco u_alu_deco (
        .alu_op      (alu_op),
        .f3          (f3),
        .op5         (op[5]),
        .f7          (f7),
        .alu_control (ALUControl)
    );

    assign pcWrite = pc_update | (branch & zero);
    assign estado  = state;

endmodule
